// File: rtl/mem_ctrl.sv
// Single-port word RAM shared by the fetch port (bit 0) and the data port (bit 1).
// One access in flight; data port has priority; access latency set by MEM_LAT.
module mem_ctrl #(
  parameter int    DEPTH_LOG2 = 10,
  parameter int    MEM_LAT    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_re,
  input  logic [31:0] if_addr,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] rdata,
  output logic [1:0]  busy,
  output logic [1:0]  done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_port;
  logic                    r_we;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic [3:0]              r_sel;
  logic [31:0]             r_rdata;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_req_d;
  logic                    w_req_any;
  logic                    w_commit;
  logic                    w_unused;

  assign w_req_d   = d_we | d_re;
  assign w_req_any = w_req_d | if_re;
  assign w_commit  = (r_state == S_ACCESS) && (r_cnt == '0) && !rst;

  // Byte-address bits outside the word index are intentionally ignored (wrap-around).
  assign w_unused = ^{d_addr[31:DEPTH_LOG2+2], d_addr[1:0],
                      if_addr[31:DEPTH_LOG2+2], if_addr[1:0]};

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    busy         = 2'b00;
    done         = 2'b00;
    unique case (r_state)
      S_IDLE:   if (w_req_any) w_next_state = S_ACCESS;
      S_ACCESS: begin
        busy = 2'b11;
        if (r_cnt == '0) w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = r_port ? 2'b10 : 2'b01;
        w_next_state = S_IDLE;
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_port  <= w_req_d;
            r_we    <= d_we;
            r_idx   <= w_req_d ? d_addr[DEPTH_LOG2+1:2] : if_addr[DEPTH_LOG2+1:2];
            r_wdata <= d_wdata;
            r_sel   <= d_sel;
            r_cnt   <= CNT_W'(MEM_LAT - 1);
          end
        end
        S_ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_we) begin
            r_rdata <= '0;
          end else begin
            r_rdata <= r_mem[r_idx];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; only the commit qualifier sees rst, so contents survive it.
  always_ff @(posedge clk) begin
    if (w_commit && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_rdata;

endmodule
